// File: rtl/inv_test_pkg.sv
// Shared types and constants for the inverter test sequencer.
// The LFSR constants are only used when INV_SEQ_LFSR_EN is defined.
package inv_test_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StSample,
        StDone
    } state_e;

    localparam logic [3:0] LFSR_SEED = 4'b1001;
    // Right-shifting Fibonacci LFSR for x^4+x^3+1: feedback = lfsr[1] ^ lfsr[0].
    localparam logic [3:0] LFSR_TAPS = 4'b0011;

endpackage

// File: rtl/inv_pattern_gen.sv
// Stimulus bit source for the sequencer. With INV_SEQ_LFSR_EN defined it is a
// 4-bit LFSR, otherwise a bit that alternates 0,1,0,1 from reseed.
module inv_pattern_gen
    import inv_test_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic reseed,
    input  logic advance,
    output logic pat_bit
);

`ifdef INV_SEQ_LFSR_EN
    logic [3:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[3:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pat_bit = lfsr_q[0];
`else
    logic alt_q, alt_d;

    always_comb begin
        alt_d = alt_q;
        if (reseed) begin
            alt_d = 1'b0;
        end else if (advance) begin
            alt_d = ~alt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alt_q <= 1'b0;
        end else begin
            alt_q <= alt_d;
        end
    end

    assign pat_bit = alt_q;
`endif

endmodule

// File: rtl/inv_test_sequencer.sv
// Drives an inverter under test with a vector sequence, samples its output after
// a settle time and counts mismatches. Pattern source selected by INV_SEQ_LFSR_EN.
module inv_test_sequencer
    import inv_test_pkg::*;
#(
    parameter int unsigned NUM_VEC = 16,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sense_y,
    output logic             drive_a,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             pass
);

    localparam int unsigned IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e           state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             drive_a_q, drive_a_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             reseed, advance, pat_bit, mismatch;

    inv_pattern_gen u_pat (
        .clk     (clk),
        .rst     (rst),
        .reseed  (reseed),
        .advance (advance),
        .pat_bit (pat_bit)
    );

    // Case inequality so that X or Z on the sensed output is a mismatch.
    assign mismatch = (sense_y !== ~drive_a_q);

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        drive_a_d = drive_a_q;
        pass_d    = pass_q;
        reseed    = 1'b0;
        advance   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StDrive;
                    idx_d     = '0;
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
                    reseed    = 1'b1;
                end
            end
            StDrive: begin
                drive_a_d = pat_bit;
                settle_d  = SETTLE_LOAD;
                state_d   = (SETTLE == 0) ? StSample : StWait;
            end
            StWait: begin
                if (settle_q == '0) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            StSample: begin
                advance = 1'b1;
                if (mismatch && (err_cnt_q != CNT_MAX)) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StDrive;
                end else begin
                    // pass is registered with done so it is valid in the done cycle.
                    state_d = StDone;
                    pass_d  = (err_cnt_d == '0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StDrive) || (state_d == StWait) || (state_d == StSample);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            settle_q  <= '0;
            idx_q     <= '0;
            err_cnt_q <= '0;
            drive_a_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            drive_a_q <= drive_a_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign drive_a = drive_a_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_cnt_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_inv_test_sequencer.sv
// Self-checking bench for inv_test_sequencer: three instances covering the
// nominal config, a 2-bit saturating counter with Z input, and SETTLE=0.
module tb_inv_test_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic       sense_a, sense_c;
    wire        sense_b;
    logic       drive_a_a, drive_a_b, drive_a_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       pass_a, pass_b, pass_c;
    logic [7:0] err_a;
    logic [1:0] err_b;
    logic [3:0] err_c;
    int         mode_a = 0;

    // mode 0: good inverter, 1: stuck-at-1, 2: stuck-at-0, 3: buffer (always wrong)
    assign sense_a = (mode_a == 0) ? ~drive_a_a :
                     (mode_a == 1) ? 1'b1 :
                     (mode_a == 2) ? 1'b0 : drive_a_a;
    assign sense_b = 1'bz;
    assign sense_c = ~drive_a_c;

    inv_test_sequencer #(.NUM_VEC(4), .SETTLE(2), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .sense_y(sense_a), .drive_a(drive_a_a),
        .busy(busy_a), .done(done_a), .err_cnt(err_a), .pass(pass_a)
    );
    inv_test_sequencer #(.NUM_VEC(8), .SETTLE(2), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .sense_y(sense_b), .drive_a(drive_a_b),
        .busy(busy_b), .done(done_b), .err_cnt(err_b), .pass(pass_b)
    );
    inv_test_sequencer #(.NUM_VEC(6), .SETTLE(0), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .sense_y(sense_c), .drive_a(drive_a_c),
        .busy(busy_c), .done(done_c), .err_cnt(err_c), .pass(pass_c)
    );

`ifdef INV_SEQ_LFSR_EN
    localparam logic [7:0] PAT_A = 8'h09;  // 1,0,0,1
    localparam logic [7:0] PAT_B = 8'h59;  // 1,0,0,1,1,0,1,0
    localparam logic [7:0] PAT_C = 8'h19;  // 1,0,0,1,1,0
`else
    localparam logic [7:0] PAT_A = 8'h0A;
    localparam logic [7:0] PAT_B = 8'hAA;
    localparam logic [7:0] PAT_C = 8'h2A;
`endif

    int sel = 0;
    logic       busy_m, done_m, drive_m, pass_m;
    logic [7:0] err_m;

    always_comb begin
        busy_m = busy_a; done_m = done_a; drive_m = drive_a_a; pass_m = pass_a; err_m = err_a;
        case (sel)
            1: begin
                busy_m = busy_b; done_m = done_b; drive_m = drive_a_b; pass_m = pass_b;
                err_m = {6'd0, err_b};
            end
            2: begin
                busy_m = busy_c; done_m = done_c; drive_m = drive_a_c; pass_m = pass_c;
                err_m = {4'd0, err_c};
            end
            default: ;
        endcase
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_start(input logic v);
        start_a = (sel == 0) ? v : 1'b0;
        start_b = (sel == 1) ? v : 1'b0;
        start_c = (sel == 2) ? v : 1'b0;
    endtask

    // One full run on instance sel; checks timing, pattern and result.
    task automatic run_seq(input string name, input int nvec, input int settle,
                           input logic [7:0] exp_pat, input logic [7:0] exp_err,
                           input logic exp_pass, input int restart_at);
        int         busy_len = 0;
        int         done_at = 0;
        int         done_cnt = 0;
        int         per = settle + 2;
        logic [7:0] pat = 8'd0;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        for (int c = 1; c <= nvec * per + 4; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            set_start(c == restart_at);
            if (c == 1) begin
                check({name, "_busy_rise"}, busy_m, 1);
                check({name, "_pass_cleared"}, pass_m, 0);
            end
            if (busy_m) busy_len++;
            if (done_m) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = c;
                    check({name, "_pass_at_done"}, pass_m, exp_pass);
                end
            end
            if ((c % per == 0) && (c / per <= nvec)) pat[c / per - 1] = drive_m;
        end
        check({name, "_busy_len"}, busy_len, nvec * per);
        check({name, "_done_at"}, done_at, nvec * per + 1);
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_pattern"}, pat, exp_pat);
        check({name, "_err_cnt"}, err_m, exp_err);
        check({name, "_pass"}, pass_m, exp_pass);
    endtask

    typedef struct {
        string      name;
        int         mode;
        logic [7:0] exp_err;
        logic       exp_pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int done_seen;
        int busy_seen;

        tbl[0] = '{"good",   0, 8'd0, 1'b1};
        tbl[1] = '{"stuck1", 1, 8'd2, 1'b0};
        tbl[2] = '{"stuck0", 2, 8'd2, 1'b0};
        tbl[3] = '{"buffer", 3, 8'd4, 1'b0};
        tbl[4] = '{"good2",  0, 8'd0, 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_drive_a", drive_a_a, 0);
        check("rst_err_b", err_b, 0);
        @(negedge clk);
        rst = 1'b0;

        sel = 0;
        for (int i = 0; i < 5; i++) begin
            mode_a = tbl[i].mode;
            run_seq(tbl[i].name, 4, 2, PAT_A, tbl[i].exp_err, tbl[i].exp_pass, 0);
        end

        sel = 1;
        run_seq("z_sat", 8, 2, PAT_B, 8'd3, 1'b0, 0);

        sel = 2;
        run_seq("settle0", 6, 0, PAT_C, 8'd0, 1'b1, 0);

        // start again during the first WAIT must not restart or shift done
        sel = 0;
        mode_a = 0;
        run_seq("ign_start", 4, 2, PAT_A, 8'd0, 1'b1, 2);

        // reset during the final SAMPLE: outputs clear next cycle, no done pulse
        mode_a = 3;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_pre_busy", busy_a, 1);
        check("mid_pre_err", err_a, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_err", err_a, 0);
        check("mid_rst_pass", pass_a, 0);
        check("mid_rst_drive_a", drive_a_a, 0);
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done_a) done_seen++;
            if (busy_a) busy_seen++;
        end
        check("mid_rst_no_done", done_seen, 0);
        check("mid_rst_no_busy", busy_seen, 0);

        mode_a = 0;
        run_seq("recover", 4, 2, PAT_A, 8'd0, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
